spi_wb_target: RTL and testbench
================================

# spi_wb_target

SPI target that terminates the host (MCU) SPI link on the FPGA side and converts received command frames into Wishbone classic bus cycles. It is the responder for the bench's SPI initiator: it decodes `WRITE_AT`, `READ_AT` and `READ_NEXT` frames, drives the register/RAM Wishbone bus, returns read data on POCI, and raises a stall flag while a bus cycle is outstanding. It sits in `top` between the `spi0_*` pins and the Wishbone interconnect.

## Interface
- `WB_ADDR_WIDTH`, 20: Wishbone address width; fixed 20 for the 3-byte address encoding.
- `DATA_WIDTH`, 8: data width; fixed 8.

- `clock_i`  in  1  system clock; all logic is on its rising edge.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `spi_cs_ni`  in  1  chip select, active-low, asynchronous to `clock_i`.
- `spi_sck_i`  in  1  SPI clock, mode 0, asynchronous.
- `spi_sd_i`  in  1  PICO data.
- `spi_sd_o`  out  1  POCI data.
- `spi_stall_o`  out  1  high while a Wishbone cycle is pending; the host must not clock further bits.
- `wb_adr_o`  out  20  Wishbone address.
- `wb_dat_o`  out  8  Wishbone write data.
- `wb_dat_i`  in  8  Wishbone read data.
- `wb_we_o`  out  1  write enable.
- `wb_cyc_o`, `wb_stb_o`  out  1 each  cycle/strobe; always asserted together.
- `wb_ack_i`  in  1  single-cycle acknowledge.

## Operation
- Synchronise `spi_cs_ni`, `spi_sck_i` and `spi_sd_i` through 2-FF synchronisers. Detect SCK rise and fall from the synchronised value and its one-cycle delay.
- Sample PICO on each SCK rise, MSB first. A byte is complete on the 8th rise.
- Frame state machine: CMD → ADDR_HI → ADDR_LO → DATA / DONE / IGNORE.
  - CMD byte: `[7:4]` is the opcode; `[3:0]` is `addr[19:16]`.
  - `4'h8` WRITE_AT: CMD, `addr[15:8]`, `addr[7:0]`, data. After the data byte, issue a WB write at addr, then `addr <= addr+1`.
  - `4'hA` READ_AT: CMD, `addr[15:8]`, `addr[7:0]`. After the 3rd byte, issue a WB read at addr, latch `rd_data <= wb_dat_i`, then `addr <= addr+1`.
  - `4'h3` READ_NEXT: CMD only, low nibble ignored. After the byte, issue a WB read at the current addr, latch it, then increment.
  - Any other opcode, or extra bytes after a frame completes: go to IGNORE until `spi_cs_ni` rises. No bus cycle.
- The address increment wraps from `20'hFFFFF` to `20'h00000`. For READ_NEXT and WRITE_AT, `addr[19:16]` is taken from the previous frame, not from the CMD low nibble.
- POCI uses an 8-bit shift register, and `spi_sd_o` is its MSB.
  - The register loads `rd_data` on synchronised CS fall and on the SCK fall that follows each 8th rise.
  - It shifts left on every other SCK fall.
  - The result is that every byte returns the last completed read. READ_NEXT therefore shifts out the value prefetched by the previous READ_AT or READ_NEXT.
- CS high (synchronised) returns the FSM to CMD and clears the bit counter. A WB cycle already in flight always runs to ack; it is never abandoned. Its address increment and read latch still apply.
- SCK edges seen while `spi_stall_o` is high are discarded. They do not count toward a byte.
- Reset: all `wb_*` outputs are 0, `spi_sd_o` is 0, `spi_stall_o` is 0, addr is 0, `rd_data` is 0, the shift register is 0, and the FSM is in CMD.

## Timing
- Input latency is 2 cycles for synchronisation plus 1 cycle for edge detect. SCK high and low phases must each be at least 4 `clock_i` cycles.
- Completion of the triggering byte is detected in cycle N. In cycle N+1, `wb_cyc_o`, `wb_stb_o` and `spi_stall_o` rise together. `wb_adr_o`, `wb_we_o` and `wb_dat_o` are valid from N+1 and stable until ack.
- `wb_ack_i` high in cycle M:
  - `rd_data` is latched (reads only) and addr is incremented at the M edge.
  - `cyc`, `stb` and `stall` are low in M+1.
- With zero-wait ack (M = N+1), stall is high for exactly 1 cycle.
- `spi_sd_o` updates 1 cycle after the synchronised SCK fall or CS fall is detected.

## Test plan
- Reset: hold `reset_n_i` low for 3 cycles with SCK toggling → all outputs 0, no `wb_cyc_o`.
- WRITE_AT: frame 0x80, 0x12, 0x34, 0x5A → exactly one WB cycle with adr 0x01234, we=1, dat 0x5A. Stall is high from cyc rise until 1 cycle after ack. Internal addr becomes 0x01235.
- READ_AT then READ_NEXT, with WB returning 0xC3 at 0x0ABCD and 0x7E at 0x0ABCE: send 0xA0, 0xAB, 0xCD, then a separate frame 0x30 → POCI during the 0x30 byte is 0xC3. A second 0x30 frame returns 0x7E.
- Wrap: READ_AT 0xAF, 0xFF, 0xFF, then READ_NEXT → the second WB read is at adr 0x00000.
- Wait states: ack delayed 10 cycles, with the host clocking 3 bits during stall → stall stays high for 11 cycles, those 3 bits are ignored, and the next byte decodes correctly.
- Abort and unknown opcode:
  - CS rises after 4 bits of the address byte → no WB cycle, and the next 0x80 frame decodes from CMD.
  - Opcode 0xF0 followed by 3 bytes → no WB cycle.

Source files
------------

// File: rtl/spi_wb_target.sv
// SPI mode-0 target that turns WRITE_AT / READ_AT / READ_NEXT frames into
// Wishbone classic cycles and returns the last completed read on POCI.
module spi_wb_target #(
  parameter int WB_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     spi_cs_ni,
  input  logic                     spi_sck_i,
  input  logic                     spi_sd_i,
  output logic                     spi_sd_o,
  output logic                     spi_stall_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i
);

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_DONE,
    ST_IGNORE
  } state_e;

  localparam logic [3:0] OP_WRITE_AT  = 4'h8;
  localparam logic [3:0] OP_READ_AT   = 4'hA;
  localparam logic [3:0] OP_READ_NEXT = 4'h3;

  logic cs_meta_q, cs_sync_q, cs_dly_q;
  logic sck_meta_q, sck_sync_q, sck_dly_q;
  logic sd_meta_q, sd_sync_q;

  state_e                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    rx_q, rx_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]    tx_q, tx_d;
  logic                     load_pend_q, load_pend_d;
  logic                     is_write_q, is_write_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;

  logic                  sck_rise, sck_fall, cs_fall;
  logic [DATA_WIDTH-1:0] byte_v;

  // SCK edges are only honoured inside a frame and while no bus cycle is pending.
  assign sck_rise = ~cs_sync_q & ~cyc_q &  sck_sync_q & ~sck_dly_q;
  assign sck_fall = ~cs_sync_q & ~cyc_q & ~sck_sync_q &  sck_dly_q;
  assign cs_fall  =  cs_dly_q  & ~cs_sync_q;
  assign byte_v   = {rx_q[DATA_WIDTH-2:0], sd_sync_q};

  always_ff @(posedge clock_i) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge
    // values, so the synchroniser chain really is two flops deep.
    if (!reset_n_i) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      sd_meta_q   <= 1'b0;
      sd_sync_q   <= 1'b0;
      state_q     <= ST_CMD;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      tx_q        <= '0;
      load_pend_q <= 1'b0;
      is_write_q  <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      cs_meta_q   <= spi_cs_ni;
      cs_sync_q   <= cs_meta_q;
      cs_dly_q    <= cs_sync_q;
      sck_meta_q  <= spi_sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_dly_q   <= sck_sync_q;
      sd_meta_q   <= spi_sd_i;
      sd_sync_q   <= sd_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      tx_q        <= tx_d;
      load_pend_q <= load_pend_d;
      is_write_q  <= is_write_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path
    // through the branches below can leave a latch behind.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    tx_d        = tx_q;
    load_pend_d = load_pend_q;
    is_write_d  = is_write_q;
    cyc_d       = cyc_q;
    we_d        = we_q;

    // An outstanding cycle always completes, even if the frame was aborted.
    if (cyc_q && wb_ack_i) begin
      cyc_d  = 1'b0;
      we_d   = 1'b0;
      addr_d = addr_q + WB_ADDR_WIDTH'(1);
      if (!we_q) rd_data_d = wb_dat_i;
    end

    if (cs_sync_q) begin
      state_d     = ST_CMD;
      bit_cnt_d   = '0;
      load_pend_d = 1'b0;
    end else if (sck_rise) begin
      rx_d      = byte_v;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        load_pend_d = 1'b1;
        case (state_q)
          ST_CMD: begin
            case (byte_v[7:4])
              OP_WRITE_AT: begin
                is_write_d = 1'b1;
                state_d    = ST_ADDR_HI;
              end
              OP_READ_AT: begin
                is_write_d   = 1'b0;
                addr_d[19:16] = byte_v[3:0];
                state_d      = ST_ADDR_HI;
              end
              OP_READ_NEXT: begin
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                state_d = ST_DONE;
              end
              default: state_d = ST_IGNORE;
            endcase
          end
          ST_ADDR_HI: begin
            addr_d[15:8] = byte_v;
            state_d      = ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_d[7:0] = byte_v;
            if (is_write_q) begin
              state_d = ST_DATA;
            end else begin
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              state_d = ST_DONE;
            end
          end
          ST_DATA: begin
            wdata_d = byte_v;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            state_d = ST_DONE;
          end
          default: state_d = ST_IGNORE;
        endcase
      end
    end

    // POCI reloads at frame start and after each byte, otherwise shifts MSB first.
    if (cs_fall) begin
      tx_d        = rd_data_q;
      load_pend_d = 1'b0;
    end else if (sck_fall) begin
      if (load_pend_q) begin
        tx_d        = rd_data_q;
        load_pend_d = 1'b0;
      end else begin
        tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign spi_sd_o    = tx_q[DATA_WIDTH-1];
  assign spi_stall_o = cyc_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = addr_q;
  assign wb_dat_o    = wdata_q;

endmodule

// File: tb/tb_spi_wb_target.sv
// Directed bench for spi_wb_target: bit-banged SPI host, Wishbone responder
// with programmable wait states, and a per-cycle handshake monitor.
module tb_spi_wb_target;

  localparam int HALF = 6;

  logic        clock_i;
  logic        reset_n_i;
  logic        spi_cs_ni;
  logic        spi_sck_i;
  logic        spi_sd_i;
  logic        spi_sd_o;
  logic        spi_stall_o;
  logic [19:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  int checks = 0;
  int errors = 0;

  int          ack_wait = 0;
  int          cyc_rises = 0;
  int          last_stall_len = 0;
  logic [19:0] last_adr = '0;
  logic        last_we = 1'b0;
  logic [7:0]  last_dat = '0;

  spi_wb_target #(.WB_ADDR_WIDTH(20), .DATA_WIDTH(8)) dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .spi_cs_ni  (spi_cs_ni),
    .spi_sck_i  (spi_sck_i),
    .spi_sd_i   (spi_sd_i),
    .spi_sd_o   (spi_sd_o),
    .spi_stall_o(spi_stall_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    case (a)
      20'h0ABCD: return 8'hC3;
      20'h0ABCE: return 8'h7E;
      20'h00000: return 8'h11;
      default:   return a[7:0] ^ 8'h55;
    endcase
  endfunction

  // Wishbone responder: acks after ack_wait extra cycles of cyc.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clock_i);
      #1;
      wb_ack_i = 1'b0;
      if (wb_cyc_o) begin
        if (wait_cnt >= ack_wait) begin
          wb_ack_i = 1'b1;
          wb_dat_i = mem_rd(wb_adr_o);
          last_adr = wb_adr_o;
          last_we  = wb_we_o;
          last_dat = wb_dat_o;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Handshake monitor: stb tracks cyc, stall tracks cyc, count cycles and stall length.
  initial begin
    logic cyc_prev;
    int   run;
    cyc_prev = 1'b0;
    run = 0;
    forever begin
      @(negedge clock_i);
      if (reset_n_i) begin
        check("stb_eq_cyc", wb_stb_o, wb_cyc_o);
        check("stall_eq_cyc", spi_stall_o, wb_cyc_o);
      end
      if (wb_cyc_o && !cyc_prev) cyc_rises++;
      cyc_prev = wb_cyc_o;
      if (spi_stall_o) begin
        run++;
      end else if (run != 0) begin
        last_stall_len = run;
        run = 0;
      end
    end
  end

  task automatic wait_stall_low();
    int n;
    n = 0;
    while (spi_stall_o && n < 100) begin
      @(negedge clock_i);
      n++;
    end
    check("stall_released", spi_stall_o, 1'b0);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_sd_i = b;
    repeat (HALF) @(negedge clock_i);
    r = spi_sd_o;
    spi_sck_i = 1'b1;
    repeat (HALF) @(negedge clock_i);
    spi_sck_i = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
    wait_stall_low();
  endtask

  task automatic cs_start();
    spi_cs_ni = 1'b0;
    repeat (HALF) @(negedge clock_i);
  endtask

  task automatic cs_stop();
    repeat (HALF) @(negedge clock_i);
    spi_cs_ni = 1'b1;
    repeat (2 * HALF) @(negedge clock_i);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    logic       rb;
    int         base;
    int         n;

    reset_n_i = 1'b0;
    spi_cs_ni = 1'b1;
    spi_sck_i = 1'b0;
    spi_sd_i  = 1'b0;

    // Reset held 3 cycles with SCK toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      spi_sck_i = ~spi_sck_i;
    end
    @(negedge clock_i);
    spi_sck_i = 1'b0;
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_adr", wb_adr_o, 20'h0);
    check("rst_dat", wb_dat_o, 8'h0);
    check("rst_sd", spi_sd_o, 1'b0);
    check("rst_stall", spi_stall_o, 1'b0);
    reset_n_i = 1'b1;
    repeat (4) @(negedge clock_i);
    check("post_rst_cyc", wb_cyc_o, 1'b0);

    // WRITE_AT 0x01234 <= 0x5A, zero-wait ack.
    base = cyc_rises;
    cs_start();
    spi_byte(8'h80, r0);
    spi_byte(8'h12, r1);
    spi_byte(8'h34, r2);
    spi_byte(8'h5A, r3);
    cs_stop();
    check("wr_one_cycle", cyc_rises, base + 1);
    check("wr_adr", last_adr, 20'h01234);
    check("wr_we", last_we, 1'b1);
    check("wr_dat", last_dat, 8'h5A);
    check("wr_stall_len", last_stall_len, 1);

    // READ_NEXT after the write reads the incremented address 0x01235.
    cs_start();
    spi_byte(8'h30, r0);
    cs_stop();
    check("rn0_poci", r0, 8'h00);
    check("rn0_adr", last_adr, 20'h01235);
    check("rn0_we", last_we, 1'b0);

    // READ_AT 0x0ABCD: every byte of this frame returns the previous read (0x35^0x55).
    base = cyc_rises;
    cs_start();
    spi_byte(8'hA0, r0);
    spi_byte(8'hAB, r1);
    spi_byte(8'hCD, r2);
    cs_stop();
    check("ra_one_cycle", cyc_rises, base + 1);
    check("ra_adr", last_adr, 20'h0ABCD);
    check("ra_we", last_we, 1'b0);
    check("ra_poci_b0", r0, 8'h60);
    check("ra_poci_b2", r2, 8'h60);

    cs_start();
    spi_byte(8'h30, r0);
    cs_stop();
    check("rn1_poci", r0, 8'hC3);
    check("rn1_adr", last_adr, 20'h0ABCE);

    cs_start();
    spi_byte(8'h30, r0);
    cs_stop();
    check("rn2_poci", r0, 8'h7E);
    check("rn2_adr", last_adr, 20'h0ABCF);

    // Address wrap from 0xFFFFF to 0x00000.
    cs_start();
    spi_byte(8'hAF, r0);
    spi_byte(8'hFF, r1);
    spi_byte(8'hFF, r2);
    cs_stop();
    check("wrap_first_adr", last_adr, 20'hFFFFF);
    cs_start();
    spi_byte(8'h30, r0);
    cs_stop();
    check("wrap_second_adr", last_adr, 20'h00000);
    check("wrap_poci", r0, 8'hAA);

    // Wait states: READ_AT 0x01200 with 10-cycle ack, 3 bits clocked during stall.
    ack_wait = 10;
    base = cyc_rises;
    cs_start();
    spi_byte(8'hA0, r0);
    spi_byte(8'h12, r1);
    for (int i = 7; i >= 1; i--) spi_bit(1'b0, rb);
    spi_sd_i = 1'b0;
    repeat (HALF) @(negedge clock_i);
    spi_sck_i = 1'b1;
    n = 0;
    while (!spi_stall_o && n < 20) begin
      @(negedge clock_i);
      n++;
    end
    check("ws_stall_seen", spi_stall_o, 1'b1);
    spi_sd_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      spi_sck_i = 1'b0;
      @(negedge clock_i);
      spi_sck_i = 1'b1;
    end
    @(negedge clock_i);
    spi_sck_i = 1'b0;
    spi_sd_i  = 1'b0;
    wait_stall_low();
    cs_stop();
    ack_wait = 0;
    check("ws_stall_len", last_stall_len, 11);
    check("ws_one_cycle", cyc_rises, base + 1);
    check("ws_adr", last_adr, 20'h01200);
    cs_start();
    spi_byte(8'h30, r0);
    cs_stop();
    check("ws_next_poci", r0, 8'h55);
    check("ws_next_adr", last_adr, 20'h01201);

    // Abort mid address byte, then a clean WRITE_AT decodes from CMD.
    base = cyc_rises;
    cs_start();
    spi_byte(8'h80, r0);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    cs_stop();
    check("abort_no_cycle", cyc_rises, base);
    cs_start();
    spi_byte(8'h80, r0);
    spi_byte(8'h01, r1);
    spi_byte(8'h02, r2);
    spi_byte(8'h03, r3);
    cs_stop();
    check("abort_next_cycle", cyc_rises, base + 1);
    check("abort_next_adr", last_adr, 20'h00102);
    check("abort_next_dat", last_dat, 8'h03);
    check("abort_next_we", last_we, 1'b1);

    // Unknown opcode followed by three bytes: no bus cycle.
    base = cyc_rises;
    cs_start();
    spi_byte(8'hF0, r0);
    spi_byte(8'h11, r1);
    spi_byte(8'h22, r2);
    spi_byte(8'h33, r3);
    cs_stop();
    check("unknown_no_cycle", cyc_rises, base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
